rv_axil_bridge: RTL and testbench

- Downstream of rv32_core's external data bus (adr/we/re/dw/dr/rdy).
- Converts core loads/stores that fall inside an address window into single AXI4-Lite master transactions toward accelerator registers and DDR on kv260.
- Stalls the core through rdy until the AXI response returns. Returns zero on dr when idle, because the core ORs dr with its local memory and sio read data.

---
 rtl/rv_bus_pkg.sv | 17 +
 rtl/rv_axil_bridge.sv | 193 +++++++++++++++++++
 tb/tb_rv_axil_bridge.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_bus_pkg.sv
// Shared definitions for the rv32_core external data bus and its AXI4-Lite bridge.
package rv_bus_pkg;

    // Bridge FSM states (kept as plain constants for older tool flows).
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWr   = 2'd1;
    localparam logic [1:0] StRd   = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [2:0] AXI_PROT_DEF  = 3'b000;

    // Default external window; the core's local decoders use the same bounds.
    localparam logic [31:0] BASE_DEF  = 32'h0001_0000;
    localparam logic [31:0] LIMIT_DEF = 32'hffff_0000;

endpackage

// File: rtl/rv_axil_bridge.sv
// Turns core loads/stores inside [BASE, LIMIT) into single AXI4-Lite transactions,
// stalling the core through rdy until the response returns.
module rv_axil_bridge
    import rv_bus_pkg::*;
#(
    parameter logic [31:0] BASE    = BASE_DEF,
    parameter logic [31:0] LIMIT   = LIMIT_DEF,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] dw,
    output logic [31:0] dr,
    output logic        rdy,
    input  logic        err_clr,
    output logic        err_resp,
    output logic        err_tmo,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    localparam logic [31:0] TmoMax  = 32'(TIMEOUT);
    localparam logic [31:0] TmoLast = 32'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic        is_read_q, is_read_d;
    logic [31:0] dr_q, dr_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_resp_q, err_resp_d;
    logic        err_tmo_q, err_tmo_d;

    logic hit;
    logic busy;
    logic bready;
    logic rready;
    logic resp_set;
    logic tmo_set;

    // Window decode and handshake-ready generation.
    always_comb begin
        hit  = (re | (we != 4'b0000)) & (adr >= BASE) & (adr < LIMIT);
        busy = (state_q == StWr) | (state_q == StRd);
        // Ready includes a handshake completing this cycle so a zero-wait slave
        // can answer in the same cycle as the address/data acceptance.
        bready = (state_q == StWr) & (~awvalid_q | m_axi_awready)
                                   & (~wvalid_q  | m_axi_wready);
        rready = (state_q == StRd) & (~arvalid_q | m_axi_arready);
    end

    // Next-state logic for the transaction FSM, timeout counter and sticky flags.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        arvalid_d  = arvalid_q;
        is_read_d  = is_read_q;
        dr_d       = dr_q;
        cnt_d      = cnt_q;
        resp_set   = 1'b0;
        tmo_set    = 1'b0;

        case (state_q)
            StIdle: begin
                if (hit) begin
                    addr_d  = {adr[31:2], 2'b00};
                    wdata_d = dw;
                    wstrb_d = we;
                    cnt_d   = '0;
                    if (we != 4'b0000) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        is_read_d = 1'b0;
                        state_d   = StWr;
                    end else begin
                        arvalid_d = 1'b1;
                        is_read_d = 1'b1;
                        state_d   = StRd;
                    end
                end
            end
            StWr: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (m_axi_bvalid && bready) begin
                    state_d  = StDone;
                    resp_set = (m_axi_bresp != AXI_RESP_OKAY);
                end
            end
            StRd: begin
                if (arvalid_q && m_axi_arready) arvalid_d = 1'b0;
                if (m_axi_rvalid && rready) begin
                    dr_d     = m_axi_rdata;
                    state_d  = StDone;
                    resp_set = (m_axi_rresp != AXI_RESP_OKAY);
                end
            end
            default: begin
                // Held core request is not re-evaluated here; it completes this cycle.
                state_d = StIdle;
            end
        endcase

        // Saturating busy-cycle count; flag fires when the count reaches TIMEOUT.
        if (busy) begin
            if (cnt_q < TmoMax) cnt_d = cnt_q + 32'd1;
            tmo_set = (cnt_q == TmoLast);
        end

        // Clear first so a coincident set event wins.
        err_resp_d = (err_resp_q & ~err_clr) | resp_set;
        err_tmo_d  = (err_tmo_q & ~err_clr) | tmo_set;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            is_read_q  <= 1'b0;
            dr_q       <= '0;
            cnt_q      <= '0;
            err_resp_q <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            is_read_q  <= is_read_d;
            dr_q       <= dr_d;
            cnt_q      <= cnt_d;
            err_resp_q <= err_resp_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

    // Output drive; dr stays zero outside a read's DONE cycle because the core ORs it in.
    always_comb begin
        rdy           = ~(((state_q == StIdle) & hit) | busy);
        dr            = ((state_q == StDone) && is_read_q) ? dr_q : 32'h0;
        err_resp      = err_resp_q;
        err_tmo       = err_tmo_q;
        m_axi_awaddr  = addr_q;
        m_axi_awprot  = AXI_PROT_DEF;
        m_axi_awvalid = awvalid_q;
        m_axi_wdata   = wdata_q;
        m_axi_wstrb   = wstrb_q;
        m_axi_wvalid  = wvalid_q;
        m_axi_bready  = bready;
        m_axi_araddr  = addr_q;
        m_axi_arprot  = AXI_PROT_DEF;
        m_axi_arvalid = arvalid_q;
        m_axi_rready  = rready;
    end

endmodule

// File: tb/tb_rv_axil_bridge.sv
// Directed bench for rv_axil_bridge: the bench plays both the core and the AXI slave.
module tb_rv_axil_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] adr;
    logic [3:0]  we;
    logic        re;
    logic [31:0] dw;
    logic [31:0] dr;
    logic        rdy;
    logic        err_clr;
    logic        err_resp;
    logic        err_tmo;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv_axil_bridge #(
        .BASE    (32'h0001_0000),
        .LIMIT   (32'hffff_0000),
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .adr           (adr),
        .we            (we),
        .re            (re),
        .dw            (dw),
        .dr            (dr),
        .rdy           (rdy),
        .err_clr       (err_clr),
        .err_resp      (err_resp),
        .err_tmo       (err_tmo),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
    endtask

    task automatic core_idle();
        adr = 32'h0; we = 4'b0; re = 1'b0; dw = 32'h0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        core_idle();
        slave_idle();
        repeat (3) cyc();
        reset = 1'b0;
        settle();
        n_tests++;
        if (rdy !== 1'b1 || dr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_core: rdy=%b dr=%h required rdy=1 dr=0", rdy, dr);
        end
        n_tests++;
        if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_axi_hs: aw/w/ar/b/r=%b required 00000",
                     {awvalid, wvalid, arvalid, bready, rready});
        end
        n_tests++;
        if (err_resp !== 1'b0 || err_tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: resp=%b tmo=%b required 0 0", err_resp, err_tmo);
        end
        n_tests++;
        if (awaddr !== 32'h0 || wdata !== 32'h0 || wstrb !== 4'h0 || awprot !== 3'h0
            || arprot !== 3'h0) begin
            n_fail++;
            $display("FAIL reset_regs: awaddr=%h wdata=%h wstrb=%h required all 0",
                     awaddr, wdata, wstrb);
        end
    endtask

    task automatic test_read();
        cyc();
        adr = 32'h0002_0008; re = 1'b1;
        settle();
        n_tests++;
        if (rdy !== 1'b0 || dr !== 32'h0) begin
            n_fail++;
            $display("FAIL read_idle: rdy=%b dr=%h required rdy=0 dr=0", rdy, dr);
        end
        cyc();
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
        settle();
        n_tests++;
        if (arvalid !== 1'b1 || araddr !== 32'h0002_0008 || rready !== 1'b1
            || rdy !== 1'b0 || dr !== 32'h0) begin
            n_fail++;
            $display("FAIL read_rd: arvalid=%b araddr=%h rready=%b rdy=%b dr=%h required 1 00020008 1 0 0",
                     arvalid, araddr, rready, rdy, dr);
        end
        cyc();
        slave_idle();
        settle();
        n_tests++;
        if (rdy !== 1'b1 || dr !== 32'h1234_5678 || arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_done: rdy=%b dr=%h arvalid=%b required 1 12345678 0",
                     rdy, dr, arvalid);
        end
        cyc();
        core_idle();
        settle();
        n_tests++;
        if (rdy !== 1'b1 || dr !== 32'h0 || arvalid !== 1'b0 || rready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_after: rdy=%b dr=%h arvalid=%b rready=%b required 1 0 0 0",
                     rdy, dr, arvalid, rready);
        end
    endtask

    task automatic test_byte_write();
        cyc();
        adr = 32'h0003_0001; we = 4'b0010; dw = 32'h0000_AB00;
        settle();
        n_tests++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_idle: rdy=%b required 0", rdy);
        end
        // Busy cycle 1: W accepted at once, AW held off.
        cyc();
        wready = 1'b1;
        settle();
        n_tests++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h0003_0000
            || wstrb !== 4'b0010 || wdata !== 32'h0000_AB00 || bready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_start: awv=%b wv=%b awaddr=%h wstrb=%b wdata=%h bready=%b required 1 1 00030000 0010 0000ab00 0",
                     awvalid, wvalid, awaddr, wstrb, wdata, bready);
        end
        // Busy cycles 2 and 3: W done, AW still waiting.
        for (int i = 0; i < 2; i++) begin
            cyc();
            wready = 1'b0;
            settle();
            n_tests++;
            if (wvalid !== 1'b0 || awvalid !== 1'b1 || bready !== 1'b0 || rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_aw_wait%0d: wv=%b awv=%b bready=%b rdy=%b required 0 1 0 0",
                         i, wvalid, awvalid, bready, rdy);
            end
        end
        // Busy cycle 4: AW handshake; bready follows in the same cycle.
        cyc();
        awready = 1'b1;
        settle();
        n_tests++;
        if (awvalid !== 1'b1 || bready !== 1'b1 || rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_aw_hs: awv=%b bready=%b rdy=%b required 1 1 0", awvalid, bready, rdy);
        end
        cyc();
        awready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        settle();
        n_tests++;
        if (awvalid !== 1'b0 || bready !== 1'b1 || rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_b: awv=%b bready=%b rdy=%b required 0 1 0", awvalid, bready, rdy);
        end
        cyc();
        slave_idle();
        settle();
        n_tests++;
        if (rdy !== 1'b1 || dr !== 32'h0 || bready !== 1'b0 || err_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done: rdy=%b dr=%h bready=%b err_resp=%b required 1 0 0 0",
                     rdy, dr, bready, err_resp);
        end
        cyc();
        core_idle();
        settle();
        n_tests++;
        if (rdy !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_after: rdy=%b awv=%b wv=%b required 1 0 0", rdy, awvalid, wvalid);
        end
    endtask

    task automatic test_out_of_window();
        logic [31:0] addrs [4];
        addrs[0] = 32'h0000_1000;
        addrs[1] = 32'hffff_0020;
        addrs[2] = 32'h0000_fffc;
        addrs[3] = 32'hffff_0000;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                cyc();
                adr = addrs[i]; re = (k == 0); we = (k == 1) ? 4'hf : 4'h0; dw = 32'h5555_aaaa;
                settle();
                n_tests++;
                if (rdy !== 1'b1 || dr !== 32'h0 || awvalid !== 1'b0 || wvalid !== 1'b0
                    || arvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL miss_%h_%0d: rdy=%b dr=%h awv=%b wv=%b arv=%b required 1 0 0 0 0",
                             addrs[i], k, rdy, dr, awvalid, wvalid, arvalid);
                end
            end
        end
        cyc();
        core_idle();
        settle();
        n_tests++;
        if (arvalid !== 1'b0 || awvalid !== 1'b0 || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_after: arv=%b awv=%b rdy=%b required 0 0 1", arvalid, awvalid, rdy);
        end
    endtask

    task automatic test_resp_err();
        // BASE itself is the lowest claimed address.
        cyc();
        adr = 32'h0001_0000; re = 1'b1;
        settle();
        n_tests++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_base_hit: rdy=%b required 0", rdy);
        end
        cyc();
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_0001; rresp = 2'b10;
        cyc();
        slave_idle();
        settle();
        n_tests++;
        if (dr !== 32'hCAFE_0001 || err_resp !== 1'b1 || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_done: dr=%h err_resp=%b rdy=%b required cafe0001 1 1",
                     dr, err_resp, rdy);
        end
        cyc();
        core_idle();
        cyc();
        settle();
        n_tests++;
        if (err_resp !== 1'b1 || dr !== 32'h0) begin
            n_fail++;
            $display("FAIL err_sticky: err_resp=%b dr=%h required 1 0", err_resp, dr);
        end
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        settle();
        n_tests++;
        if (err_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: err_resp=%b required 0", err_resp);
        end
    endtask

    task automatic test_timeout();
        cyc();
        adr = 32'h0004_0000; we = 4'hf; dw = 32'h0bad_f00d;
        // Busy cycles 1..40 with bvalid withheld.
        for (int b = 1; b <= 40; b++) begin
            cyc();
            awready = (b == 1); wready = (b == 1);
            err_clr = (b == 16); // coincides with the set event; set must win
            settle();
            n_tests++;
            if (rdy !== 1'b0 || err_tmo !== (b > 16)) begin
                n_fail++;
                $display("FAIL tmo_busy%0d: rdy=%b err_tmo=%b required 0 %b",
                         b, rdy, err_tmo, (b > 16));
            end
        end
        cyc();
        err_clr = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        settle();
        n_tests++;
        if (bready !== 1'b1 || rdy !== 1'b0 || err_tmo !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_b: bready=%b rdy=%b err_tmo=%b required 1 0 1", bready, rdy, err_tmo);
        end
        cyc();
        slave_idle();
        settle();
        n_tests++;
        if (rdy !== 1'b1 || dr !== 32'h0) begin
            n_fail++;
            $display("FAIL tmo_done: rdy=%b dr=%h required 1 0", rdy, dr);
        end
        cyc();
        core_idle();
        err_clr = 1'b1;
        settle();
        n_tests++;
        if (rdy !== 1'b1 || err_tmo !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_idle: rdy=%b err_tmo=%b required 1 1", rdy, err_tmo);
        end
        cyc();
        err_clr = 1'b0;
        settle();
        n_tests++;
        if (err_tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_clear: err_tmo=%b required 0", err_tmo);
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        adr = 32'h0005_0000; re = 1'b1;
        cyc();
        settle();
        n_tests++;
        if (arvalid !== 1'b1 || rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_rd: arvalid=%b rdy=%b required 1 0", arvalid, rdy);
        end
        reset = 1'b1;
        re = 1'b0;
        cyc();
        reset = 1'b0;
        settle();
        n_tests++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || rdy !== 1'b1 || dr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_after: arv=%b rready=%b rdy=%b dr=%h required 0 0 1 0",
                     arvalid, rready, rdy, dr);
        end
        // An IDLE bridge must accept a fresh request immediately.
        cyc();
        adr = 32'h0006_0004; re = 1'b1;
        cyc();
        settle();
        n_tests++;
        if (arvalid !== 1'b1 || araddr !== 32'h0006_0004) begin
            n_fail++;
            $display("FAIL rst_mid_new: arv=%b araddr=%h required 1 00060004", arvalid, araddr);
        end
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0;
        cyc();
        slave_idle();
        core_idle();
    endtask

    initial begin
        test_reset();
        test_read();
        test_byte_write();
        test_out_of_window();
        test_resp_err();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
